snake_head_stepper: RTL and testbench

- Sequential successor to the combinational one-step direction updater: owns the snake head position and direction registers and advances the head one cell per step tick.
- Parametrised grid size, step rate and edge mode (wrap-around or wall).
- Rejects 180° reversals and buffers one direction request between steps.
- Sits between the keypad/button decoder and the body/collision/VGA logic; downstream blocks sample head_x/head_y on step_pulse.

---
 rtl/snake_head_stepper_pkg.sv | 27 ++
 rtl/snake_head_stepper_if.sv | 24 ++
 rtl/snake_head_stepper_step_timer.sv | 27 ++
 rtl/snake_head_stepper.sv | 176 +++++++++++++++++
 tb/tb_snake_head_stepper.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_head_stepper_pkg.sv
// Shared encodings and defaults for the snake head stepper slice.
package snake_head_stepper_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_e;

    localparam int unsigned DEF_GRID_W   = 75;
    localparam int unsigned DEF_GRID_H   = 75;
    localparam int unsigned DEF_COORD_W  = 7;
    localparam int unsigned DEF_STEP_DIV = 25000000;

    // Opposite directions share the axis bit and differ in the sign bit.
    function automatic logic is_reversal(logic [1:0] req, logic [1:0] cur);
        return (req[1] == cur[1]) && (req[0] != cur[0]);
    endfunction

endpackage

// File: rtl/snake_head_stepper_if.sv
// Control/request inputs and head-state outputs of the snake head stepper.
interface snake_head_stepper_if #(
    parameter int unsigned COORD_W = 7
);
    logic               en;
    logic               restart;
    logic               dir_valid;
    logic [1:0]         dir_in;
    logic [COORD_W-1:0] head_x;
    logic [COORD_W-1:0] head_y;
    logic [1:0]         dir;
    logic               step_pulse;
    logic               dead;

    modport master (
        output en, restart, dir_valid, dir_in,
        input  head_x, head_y, dir, step_pulse, dead
    );

    modport slave (
        input  en, restart, dir_valid, dir_in,
        output head_x, head_y, dir, step_pulse, dead
    );
endinterface

// File: rtl/snake_head_stepper_step_timer.sv
// Step-rate divider: counts 0..STEP_DIV-1 while enabled, flags the last count.
module snake_step_timer #(
    parameter int unsigned STEP_DIV = 25000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tick_c
);
    localparam int unsigned    CNT_W = $clog2(STEP_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick_c = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick_c ? '0 : cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/snake_head_stepper.sv
// Snake head position/direction owner: steps one cell per tick, buffers one turn request.
module snake_head_stepper
    import snake_head_stepper_pkg::*;
#(
    parameter int unsigned GRID_W   = DEF_GRID_W,
    parameter int unsigned GRID_H   = DEF_GRID_H,
    parameter int unsigned COORD_W  = DEF_COORD_W,
    parameter int unsigned STEP_DIV = DEF_STEP_DIV,
    parameter bit          WRAP_EN  = 1'b1,
    parameter int unsigned INIT_X   = 37,
    parameter int unsigned INIT_Y   = 37,
    parameter logic [1:0]  INIT_DIR = DIR_RIGHT
) (
    input  logic clk,
    input  logic rstn,
    snake_head_stepper_if.slave bus
);
    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX  = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0] X_INIT = COORD_W'(INIT_X);
    localparam logic [COORD_W-1:0] Y_INIT = COORD_W'(INIT_Y);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] head_x_q, head_x_d;
    logic [COORD_W-1:0] head_y_q, head_y_d;
    logic [1:0]         dir_q, dir_d;
    logic [1:0]         pend_q, pend_d;
    logic               pend_vld_q, pend_vld_d;
    logic               pulse_q, pulse_d;
    logic               dead_q, dead_d;

    logic               tick_c;
    logic [1:0]         step_dir_c;
    logic [COORD_W-1:0] mv_x_c, mv_y_c;
    logic               hit_c;

    snake_step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (bus.restart || (state_q != ST_RUN)),
        .en     (bus.en && (state_q == ST_RUN)),
        .tick_c (tick_c)
    );

    // A buffered turn takes effect on the step itself.
    assign step_dir_c = pend_vld_q ? pend_q : dir_q;

    // Candidate next cell; edges are tested before any add/subtract.
    always_comb begin
        mv_x_c = head_x_q;
        mv_y_c = head_y_q;
        hit_c  = 1'b0;
        case (dir_e'(step_dir_c))
            DIR_LEFT: begin
                if (head_x_q == '0) begin
                    if (WRAP_EN) mv_x_c = X_MAX;
                    else         hit_c  = 1'b1;
                end else begin
                    mv_x_c = head_x_q - COORD_W'(1);
                end
            end
            DIR_RIGHT: begin
                if (head_x_q == X_MAX) begin
                    if (WRAP_EN) mv_x_c = '0;
                    else         hit_c  = 1'b1;
                end else begin
                    mv_x_c = head_x_q + COORD_W'(1);
                end
            end
            DIR_UP: begin
                if (head_y_q == '0) begin
                    if (WRAP_EN) mv_y_c = Y_MAX;
                    else         hit_c  = 1'b1;
                end else begin
                    mv_y_c = head_y_q - COORD_W'(1);
                end
            end
            default: begin
                if (head_y_q == Y_MAX) begin
                    if (WRAP_EN) mv_y_c = '0;
                    else         hit_c  = 1'b1;
                end else begin
                    mv_y_c = head_y_q + COORD_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        dir_d      = dir_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        pulse_d    = 1'b0;

        if (bus.restart) begin
            state_d    = ST_IDLE;
            head_x_d   = X_INIT;
            head_y_d   = Y_INIT;
            dir_d      = INIT_DIR;
            pend_d     = '0;
            pend_vld_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.dir_valid && !is_reversal(bus.dir_in, dir_q)) begin
                        pend_d     = bus.dir_in;
                        pend_vld_d = 1'b1;
                    end
                    if (bus.en) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (tick_c) begin
                        dir_d      = step_dir_c;
                        pend_vld_d = 1'b0;
                        pulse_d    = 1'b1;
                        if (hit_c) begin
                            state_d = ST_DEAD;
                        end else begin
                            head_x_d = mv_x_c;
                            head_y_d = mv_y_c;
                        end
                        // Same-cycle request is judged against the post-step direction.
                        if (bus.dir_valid && !is_reversal(bus.dir_in, step_dir_c)) begin
                            pend_d     = bus.dir_in;
                            pend_vld_d = 1'b1;
                        end
                    end else if (bus.dir_valid && !is_reversal(bus.dir_in, dir_q)) begin
                        pend_d     = bus.dir_in;
                        pend_vld_d = 1'b1;
                    end
                end
                ST_DEAD: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        dead_d = (state_d == ST_DEAD);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            head_x_q   <= X_INIT;
            head_y_q   <= Y_INIT;
            dir_q      <= INIT_DIR;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            pulse_q    <= 1'b0;
            dead_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            pulse_q    <= pulse_d;
            dead_q     <= dead_d;
        end
    end

    assign bus.head_x     = head_x_q;
    assign bus.head_y     = head_y_q;
    assign bus.dir        = dir_q;
    assign bus.step_pulse = pulse_q;
    assign bus.dead       = dead_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// Bench for snake_head_stepper: wrap and wall instances driven identically, checked against a cell-level model.
module tb_snake_head_stepper;

    localparam int STEP_DIV = 4;
    localparam int GW       = 75;
    localparam int GH       = 75;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en, restart, dv;
    logic [1:0] din;
    bit         cmp_on = 1'b0;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    snake_head_stepper_if #(.COORD_W(7)) if0 ();
    snake_head_stepper_if #(.COORD_W(7)) if1 ();

    assign if0.en = en;  assign if0.restart = restart;
    assign if0.dir_valid = dv;  assign if0.dir_in = din;
    assign if1.en = en;  assign if1.restart = restart;
    assign if1.dir_valid = dv;  assign if1.dir_in = din;

    snake_head_stepper #(
        .GRID_W(GW), .GRID_H(GH), .COORD_W(7), .STEP_DIV(STEP_DIV), .WRAP_EN(1'b1),
        .INIT_X(37), .INIT_Y(37), .INIT_DIR(2'b01)
    ) u_wrap (.clk(clk), .rstn(rstn), .bus(if0.slave));

    snake_head_stepper #(
        .GRID_W(GW), .GRID_H(GH), .COORD_W(7), .STEP_DIV(STEP_DIV), .WRAP_EN(1'b0),
        .INIT_X(37), .INIT_Y(37), .INIT_DIR(2'b01)
    ) u_wall (.clk(clk), .rstn(rstn), .bus(if1.slave));

    // Model: st 0 idle, 1 running, 2 dead; phase = enabled running cycles since last step.
    typedef struct {
        int x; int y; int d; int pend; int st; int phase; bit pulse;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mdl_init();
        mdl_t r;
        r.x = 37; r.y = 37; r.d = 1; r.pend = -1; r.st = 0; r.phase = 0; r.pulse = 0;
        return r;
    endfunction

    function automatic bit opposite(int a, int b);
        int opp [4];
        opp = '{1, 0, 3, 2};
        return a == opp[b];
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, bit rs, bit e, bit v, int req, bit wrap);
        mdl_t r;
        bit   stepping;
        int   nd, nx, ny;
        r = m;
        r.pulse = 0;
        if (rs) return mdl_init();
        if (m.st == 0) begin
            if (v && !opposite(req, m.d)) r.pend = req;
            if (e) begin r.st = 1; r.phase = 0; end
        end else if (m.st == 1) begin
            stepping = e && (m.phase + 1 == STEP_DIV);
            if (e) r.phase = stepping ? 0 : m.phase + 1;
            if (stepping) begin
                nd = (m.pend >= 0) ? m.pend : m.d;
                r.d = nd; r.pend = -1; r.pulse = 1;
                nx = m.x + ((nd == 0) ? -1 : (nd == 1) ? 1 : 0);
                ny = m.y + ((nd == 2) ? -1 : (nd == 3) ? 1 : 0);
                if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
                    if (wrap) begin r.x = (nx + GW) % GW; r.y = (ny + GH) % GH; end
                    else r.st = 2;
                end else begin
                    r.x = nx; r.y = ny;
                end
                if (v && !opposite(req, nd)) r.pend = req;
            end else if (v && !opposite(req, m.d)) begin
                r.pend = req;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m0 = mdl_init();
            m1 = mdl_init();
        end else begin
            m0 = mdl_next(m0, restart, en, dv, int'(din), 1'b1);
            m1 = mdl_next(m1, restart, en, dv, int'(din), 1'b0);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("wrap_x", int'(if0.head_x), m0.x);
            check("wrap_y", int'(if0.head_y), m0.y);
            check("wrap_dir", int'(if0.dir), m0.d);
            check("wrap_pulse", int'(if0.step_pulse), int'(m0.pulse));
            check("wrap_dead", int'(if0.dead), int'(m0.st == 2));
            check("wall_x", int'(if1.head_x), m1.x);
            check("wall_y", int'(if1.head_y), m1.y);
            check("wall_dir", int'(if1.dir), m1.d);
            check("wall_pulse", int'(if1.step_pulse), int'(m1.pulse));
            check("wall_dead", int'(if1.dead), int'(m1.st == 2));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req(input logic [1:0] d);
        dv = 1'b1; din = d;
        @(negedge clk);
        dv = 1'b0;
    endtask

    task automatic wait_steps(input int n);
        int seen = 0;
        for (int k = 0; k < n * STEP_DIV * 3 + 20 && seen < n; k++) begin
            @(negedge clk);
            if (if0.step_pulse) seen++;
        end
        check("step_timeout", seen, n);
    endtask

    task automatic first_step_latency(input string name);
        int k = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (if0.step_pulse) begin k = i; break; end
        end
        check(name, k, STEP_DIV + 1);
    endtask

    task automatic do_restart();
        restart = 1'b1; en = 1'b0;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic lit(input string name, input int x, input int y, input int ex, input int ey);
        check({name, "_x"}, x, ex);
        check({name, "_y"}, y, ey);
    endtask

    initial begin
        m0 = mdl_init(); m1 = mdl_init();
        rstn = 1'b0; en = 1'b0; restart = 1'b0; dv = 1'b0; din = 2'b00;
        cyc(3);
        lit("rst", int'(if0.head_x), int'(if0.head_y), 37, 37);
        check("rst_dir", int'(if0.dir), 1);
        check("rst_pulse", int'(if0.step_pulse), 0);
        check("rst_dead", int'(if1.dead), 0);
        cmp_on = 1'b1;

        // Free run from reset
        rstn = 1'b1; en = 1'b1;
        first_step_latency("t1_first_step");
        lit("t1_s1", int'(if0.head_x), int'(if0.head_y), 38, 37);
        wait_steps(1);
        lit("t1_s2", int'(if0.head_x), int'(if0.head_y), 39, 37);
        wait_steps(1);
        lit("t1_s3", int'(if0.head_x), int'(if0.head_y), 40, 37);

        // Async reset mid-count
        cyc(2);
        #2 rstn = 1'b0;
        #1;
        lit("t6_rst", int'(if0.head_x), int'(if0.head_y), 37, 37);
        check("t6_rst_dir", int'(if0.dir), 1);
        check("t6_rst_pulse", int'(if0.step_pulse), 0);
        @(negedge clk);
        rstn = 1'b1;
        first_step_latency("t6_first_step");
        lit("t6_s1", int'(if0.head_x), int'(if0.head_y), 38, 37);

        // Request landing in the step cycle
        do_restart();
        en = 1'b1;
        wait_steps(1);
        lit("t5_s1", int'(if0.head_x), int'(if0.head_y), 38, 37);
        cyc(3);
        req(2'b10);
        lit("t5_s2", int'(if0.head_x), int'(if0.head_y), 39, 37);
        check("t5_s2_dir", int'(if0.dir), 1);
        check("t5_s2_pulse", int'(if0.step_pulse), 1);
        wait_steps(1);
        lit("t5_s3", int'(if0.head_x), int'(if0.head_y), 39, 36);
        check("t5_s3_dir", int'(if0.dir), 2);

        // Reversal rejection, latest request wins
        do_restart();
        en = 1'b1;
        wait_steps(1);
        req(2'b00);
        wait_steps(1);
        lit("t2_rev", int'(if0.head_x), int'(if0.head_y), 39, 37);
        check("t2_rev_dir", int'(if0.dir), 1);
        req(2'b10);
        req(2'b11);
        wait_steps(1);
        lit("t2_latest", int'(if0.head_x), int'(if0.head_y), 39, 38);
        check("t2_latest_dir", int'(if0.dir), 3);

        // en low freezes motion but still captures a request
        cyc(1);
        en = 1'b0;
        cyc(2);
        req(2'b00);
        cyc(4);
        en = 1'b1;
        wait_steps(1);
        lit("frz", int'(if0.head_x), int'(if0.head_y), 38, 38);
        check("frz_dir", int'(if0.dir), 0);

        // Right edge: wrap vs wall
        do_restart();
        req(2'b10);
        en = 1'b1;
        wait_steps(27);
        lit("t4_up", int'(if0.head_x), int'(if0.head_y), 37, 10);
        req(2'b01);
        wait_steps(37);
        lit("t4_edge_wrap", int'(if0.head_x), int'(if0.head_y), 74, 10);
        lit("t4_edge_wall", int'(if1.head_x), int'(if1.head_y), 74, 10);
        wait_steps(1);
        lit("t3_wrap_x", int'(if0.head_x), int'(if0.head_y), 0, 10);
        lit("t4_hit", int'(if1.head_x), int'(if1.head_y), 74, 10);
        check("t4_hit_pulse", int'(if1.step_pulse), 1);
        check("t4_hit_dead", int'(if1.dead), 1);
        check("t3_wrap_dead", int'(if0.dead), 0);
        @(negedge clk);
        check("t4_dead_pulse", int'(if1.step_pulse), 0);
        req(2'b11);
        cyc(6);
        check("t4_dead_dir", int'(if1.dir), 1);
        lit("t4_dead_hold", int'(if1.head_x), int'(if1.head_y), 74, 10);
        do_restart();
        lit("t4_rs_wall", int'(if1.head_x), int'(if1.head_y), 37, 37);
        lit("t4_rs_wrap", int'(if0.head_x), int'(if0.head_y), 37, 37);
        check("t4_rs_dead", int'(if1.dead), 0);

        // Top edge: wrap vs wall
        req(2'b10);
        en = 1'b1;
        wait_steps(37);
        lit("t3_top", int'(if0.head_x), int'(if0.head_y), 37, 0);
        req(2'b00);
        wait_steps(32);
        lit("t3_left", int'(if0.head_x), int'(if0.head_y), 5, 0);
        req(2'b10);
        wait_steps(1);
        lit("t3_wrap_y", int'(if0.head_x), int'(if0.head_y), 5, 74);
        lit("t3_wall_y", int'(if1.head_x), int'(if1.head_y), 5, 0);
        check("t3_wall_dead", int'(if1.dead), 1);

        cyc(4);
        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
